// File: rtl/ip_tx_pkg.sv
// Shared definitions for the IPv4 transmit stage: FSM encoding, fixed header
// field values and the one's-complement fold used by the checksum pipeline.
package ip_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_MAC,
    CALC,
    ARM,
    SEND_HDR,
    SEND_DATA,
    DONE
  } ip_tx_state_e;

  localparam int         IP_HDR_LEN   = 20;
  localparam logic [7:0] IP_VER_IHL   = 8'h45;
  localparam logic [7:0] IP_PROTO_UDP = 8'h11;
  localparam logic [7:0] IP_FLAGS_DF  = 8'h40;

  // Adds the carry nibble back into the low 16 bits.
  function automatic logic [19:0] csum_fold(input logic [19:0] acc);
    return {4'd0, acc[15:0]} + {16'd0, acc[19:16]};
  endfunction

endpackage

// File: rtl/ip_tx_fifo.sv
// Synchronous byte FIFO, depth 2**DEPTH_LOG2, with a synchronous flush.
// Writes when full and reads when empty are dropped.
module ip_tx_fifo #(
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  rd_en,
  output logic [7:0]            rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;

  assign empty   = (count == '0);
  assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ip_tx.sv
// IPv4 transmit stage: prepends a 20-byte header with checksum to the UDP stream.
// Define IP_TX_ID_INC_EN to make the identification field count completed packets.
//   state     | meaning
//   IDLE      | waiting for udp_send_request
//   WAIT_MAC  | requesting the MAC, total length registered
//   CALC      | 3-cycle header checksum
//   ARM       | accepting UDP bytes, waiting for the first one
//   SEND_HDR  | emitting the 20 header bytes
//   SEND_DATA | draining the FIFO, len_q bytes
//   DONE      | ack pulse, identification update
import ip_tx_pkg::*;

module ip_tx #(
  parameter logic [31:0] LOCAL_IP        = 32'hC0A8010B,
  parameter logic [7:0]  IP_TTL          = 8'h40,
  parameter int          FIFO_DEPTH_LOG2 = 5
) (
  input  logic        ip_send_clk,
  input  logic        rst,
  input  logic        udp_send_request,
  input  logic        udp_data_in_valid,
  input  logic [7:0]  udp_data_in,
  input  logic [15:0] udp_packet_length,
  input  logic [31:0] dest_ip,
  output logic        ip_send_ready,
  output logic        ip_send_ack,
  output logic        ip_send_request,
  input  logic        mac_send_ready,
  output logic        ip_data_out_valid,
  output logic [7:0]  ip_data_out,
  output logic [15:0] ip_total_length
);

  ip_tx_state_e state_q, state_d;

  logic [15:0] len_q;
  logic [31:0] dst_q;
  logic [19:0] acc_q;
  logic [19:0] acc_fold;
  logic [19:0] hdr_sum;
  logic [15:0] csum_q;
  logic [15:0] id_q;
  logic [1:0]  calc_cnt;
  logic [4:0]  hdr_cnt;
  logic [15:0] wr_cnt;
  logic [15:0] rd_cnt;
  logic [7:0]  hdr_byte;

  logic                   fifo_wr;
  logic                   fifo_rd;
  logic                   fifo_flush;
  logic [7:0]             fifo_dout;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic [FIFO_DEPTH_LOG2:0] fifo_level_unused;

  assign ip_send_ready = ((state_q == ARM) || (state_q == SEND_HDR) || (state_q == SEND_DATA))
                         && (wr_cnt < len_q);
  assign fifo_wr    = udp_data_in_valid && ip_send_ready && !fifo_full;
  assign fifo_flush = rst || (state_q == IDLE);
  assign acc_fold   = csum_fold(acc_q);

  assign hdr_sum = 20'({IP_VER_IHL, 8'h00}) + 20'(ip_total_length) + 20'(id_q)
                 + 20'({IP_FLAGS_DF, 8'h00}) + 20'({IP_TTL, IP_PROTO_UDP})
                 + 20'(LOCAL_IP[31:16]) + 20'(LOCAL_IP[15:0])
                 + 20'(dst_q[31:16]) + 20'(dst_q[15:0]);

  ip_tx_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
    .clk     (ip_send_clk),
    .flush   (fifo_flush),
    .wr_en   (fifo_wr),
    .wr_data (udp_data_in),
    .rd_en   (fifo_rd),
    .rd_data (fifo_dout),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_level_unused)
  );

  always_ff @(posedge ip_send_clk) begin
    if (rst) begin
      state_q         <= IDLE;
      len_q           <= '0;
      dst_q           <= '0;
      acc_q           <= '0;
      csum_q          <= '0;
      calc_cnt        <= '0;
      hdr_cnt         <= '0;
      wr_cnt          <= '0;
      rd_cnt          <= '0;
      ip_total_length <= '0;
    end else begin
      state_q <= state_d;
      if (fifo_wr) wr_cnt <= wr_cnt + 16'd1;
      case (state_q)
        IDLE: begin
          if (udp_send_request) begin
            len_q <= udp_packet_length;
            dst_q <= dest_ip;
          end
        end
        WAIT_MAC: begin
          ip_total_length <= len_q + 16'(IP_HDR_LEN);
          calc_cnt        <= '0;
        end
        CALC: begin
          calc_cnt <= calc_cnt + 2'd1;
          wr_cnt   <= '0;
          rd_cnt   <= '0;
          hdr_cnt  <= '0;
          case (calc_cnt)
            2'd0:    acc_q  <= hdr_sum;
            2'd1:    acc_q  <= acc_fold;
            default: csum_q <= ~acc_fold[15:0];
          endcase
        end
        SEND_HDR:  hdr_cnt <= hdr_cnt + 5'd1;
        SEND_DATA: if (fifo_rd) rd_cnt <= rd_cnt + 16'd1;
        default: ;
      endcase
    end
  end

`ifdef IP_TX_ID_INC_EN
  always_ff @(posedge ip_send_clk) begin
    if (rst)                   id_q <= '0;
    else if (state_q == DONE)  id_q <= id_q + 16'd1;
  end
`else
  assign id_q = 16'h0000;
`endif

  always_comb begin
    hdr_byte = 8'h00;
    case (hdr_cnt)
      5'd0:  hdr_byte = IP_VER_IHL;
      5'd1:  hdr_byte = 8'h00;
      5'd2:  hdr_byte = ip_total_length[15:8];
      5'd3:  hdr_byte = ip_total_length[7:0];
      5'd4:  hdr_byte = id_q[15:8];
      5'd5:  hdr_byte = id_q[7:0];
      5'd6:  hdr_byte = IP_FLAGS_DF;
      5'd7:  hdr_byte = 8'h00;
      5'd8:  hdr_byte = IP_TTL;
      5'd9:  hdr_byte = IP_PROTO_UDP;
      5'd10: hdr_byte = csum_q[15:8];
      5'd11: hdr_byte = csum_q[7:0];
      5'd12: hdr_byte = LOCAL_IP[31:24];
      5'd13: hdr_byte = LOCAL_IP[23:16];
      5'd14: hdr_byte = LOCAL_IP[15:8];
      5'd15: hdr_byte = LOCAL_IP[7:0];
      5'd16: hdr_byte = dst_q[31:24];
      5'd17: hdr_byte = dst_q[23:16];
      5'd18: hdr_byte = dst_q[15:8];
      5'd19: hdr_byte = dst_q[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d           = state_q;
    ip_send_request   = 1'b0;
    ip_send_ack       = 1'b0;
    ip_data_out_valid = 1'b0;
    ip_data_out       = 8'h00;
    fifo_rd           = 1'b0;
    case (state_q)
      IDLE:     if (udp_send_request) state_d = WAIT_MAC;
      WAIT_MAC: begin
        ip_send_request = 1'b1;
        if (mac_send_ready) state_d = CALC;
      end
      CALC:     if (calc_cnt == 2'd2) state_d = ARM;
      // A zero-length payload never produces a write, so start the header directly.
      ARM:      if (fifo_wr || (len_q == 16'd0)) state_d = SEND_HDR;
      SEND_HDR: begin
        ip_data_out_valid = 1'b1;
        ip_data_out       = hdr_byte;
        if (hdr_cnt == 5'(IP_HDR_LEN - 1))
          state_d = (len_q == 16'd0) ? DONE : SEND_DATA;
      end
      SEND_DATA: begin
        if (!fifo_empty) begin
          ip_data_out_valid = 1'b1;
          ip_data_out       = fifo_dout;
          fifo_rd           = 1'b1;
          if (rd_cnt == len_q - 16'd1) state_d = DONE;
        end
      end
      DONE: begin
        ip_send_ack = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ip_tx.sv
// Directed bench for ip_tx: header bytes, checksum, id sequencing, MAC stall,
// late UDP start, mid-packet reset and zero payload.
module tb_ip_tx;

`ifdef IP_TX_ID_INC_EN
  localparam int ID_INC = 1;
`else
  localparam int ID_INC = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        udp_send_request;
  logic        udp_data_in_valid;
  logic [7:0]  udp_data_in;
  logic [15:0] udp_packet_length;
  logic [31:0] dest_ip;
  logic        ip_send_ready;
  logic        ip_send_ack;
  logic        ip_send_request;
  logic        mac_send_ready;
  logic        ip_data_out_valid;
  logic [7:0]  ip_data_out;
  logic [15:0] ip_total_length;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ip_tx u_dut (
    .ip_send_clk       (clk),
    .rst               (rst),
    .udp_send_request  (udp_send_request),
    .udp_data_in_valid (udp_data_in_valid),
    .udp_data_in       (udp_data_in),
    .udp_packet_length (udp_packet_length),
    .dest_ip           (dest_ip),
    .ip_send_ready     (ip_send_ready),
    .ip_send_ack       (ip_send_ack),
    .ip_send_request   (ip_send_request),
    .mac_send_ready    (mac_send_ready),
    .ip_data_out_valid (ip_data_out_valid),
    .ip_data_out       (ip_data_out),
    .ip_total_length   (ip_total_length)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, 32'(ip_data_out_valid), 0);
    chk({tag, "_data"},  32'(ip_data_out), 0);
    chk({tag, "_req"},   32'(ip_send_request), 0);
    chk({tag, "_rdy"},   32'(ip_send_ready), 0);
    chk({tag, "_ack"},   32'(ip_send_ack), 0);
    chk({tag, "_tlen"},  32'(ip_total_length), 0);
  endtask

  // Called on a falling edge with the DUT in IDLE; returns on a falling edge.
  task automatic send_pkt(input logic [15:0] len, input int mac_wait, input int udp_wait,
                          input int abort_at, input logic [15:0] exp_id,
                          input logic [15:0] exp_csum, input logic [7:0] seed);
    logic [7:0]  exp_b [64];
    logic [7:0]  got_b [64];
    logic [15:0] tl;
    int n_got, first, last, ack_cnt, ack_cyc, sent;
    bit aborted, stop;

    tl = len + 16'd20;
    exp_b[0]  = 8'h45;  exp_b[1]  = 8'h00;
    exp_b[2]  = tl[15:8]; exp_b[3] = tl[7:0];
    exp_b[4]  = exp_id[15:8]; exp_b[5] = exp_id[7:0];
    exp_b[6]  = 8'h40;  exp_b[7]  = 8'h00;
    exp_b[8]  = 8'h40;  exp_b[9]  = 8'h11;
    exp_b[10] = exp_csum[15:8]; exp_b[11] = exp_csum[7:0];
    exp_b[12] = 8'hC0;  exp_b[13] = 8'hA8; exp_b[14] = 8'h01; exp_b[15] = 8'h0B;
    exp_b[16] = 8'hC0;  exp_b[17] = 8'hA8; exp_b[18] = 8'h01; exp_b[19] = 8'h03;
    for (int k = 0; k < 44; k++) exp_b[20 + k] = seed + 8'(k * 3);

    udp_send_request  = 1'b1;
    udp_packet_length = len;
    dest_ip           = 32'hC0A80103;
    @(negedge clk);
    udp_send_request  = 1'b0;
    chk("req_in_wait", 32'(ip_send_request), 1);
    for (int i = 0; i < mac_wait; i++) begin
      chk("stall_req",   32'(ip_send_request), 1);
      chk("stall_rdy",   32'(ip_send_ready), 0);
      chk("stall_valid", 32'(ip_data_out_valid), 0);
      // A second request while busy must not relatch the length.
      udp_send_request  = 1'b1;
      udp_packet_length = 16'h0099;
      @(negedge clk);
    end
    udp_send_request  = 1'b0;
    udp_packet_length = len;
    mac_send_ready    = 1'b1;
    @(negedge clk);
    mac_send_ready = 1'b0;
    chk("calc_rdy",   32'(ip_send_ready), 0);
    chk("calc_valid", 32'(ip_data_out_valid), 0);
    repeat (3) @(negedge clk);
    chk("total_len", 32'(ip_total_length), 32'(tl));
    for (int i = 0; i < udp_wait; i++) begin
      chk("arm_valid", 32'(ip_data_out_valid), 0);
      chk("arm_rdy",   32'(ip_send_ready), 32'(len != 0));
      @(negedge clk);
    end

    n_got = 0; first = -1; last = -1; ack_cnt = 0; ack_cyc = -1; sent = 0;
    aborted = 1'b0; stop = 1'b0;
    for (int cyc = 0; cyc < 300 && !stop; cyc++) begin
      if (ip_data_out_valid) begin
        if (n_got < 64) got_b[n_got] = ip_data_out;
        n_got++;
        if (first < 0) first = cyc;
        last = cyc;
      end else begin
        chk("data_zero_when_idle", 32'(ip_data_out), 0);
      end
      if (ip_send_ack) begin
        ack_cnt++;
        if (ack_cyc < 0) ack_cyc = cyc;
      end
      chk("stream_rdy", 32'(ip_send_ready), 32'(sent < int'(len)));
      if (abort_at >= 0 && n_got == 20 + abort_at + 1) begin
        rst = 1'b1;
        udp_data_in_valid = 1'b0;
        udp_data_in       = 8'h00;
        @(negedge clk);
        chk_idle_outputs("after_rst");
        rst = 1'b0;
        aborted = 1'b1;
        stop = 1'b1;
      end else if (ack_cyc >= 0 && cyc > ack_cyc) begin
        stop = 1'b1;
      end else begin
        if (sent < int'(len) + 2) begin
          udp_data_in_valid = 1'b1;
          udp_data_in       = (sent < int'(len)) ? seed + 8'(sent * 3) : 8'hEE;
          sent++;
        end else begin
          udp_data_in_valid = 1'b0;
          udp_data_in       = 8'h00;
        end
        @(negedge clk);
      end
    end
    udp_data_in_valid = 1'b0;
    udp_data_in       = 8'h00;

    if (!aborted) begin
      chk("ack_seen",   32'(ack_cyc >= 0), 1);
      chk("n_bytes",    32'(n_got), 32'(20 + int'(len)));
      chk("first_cyc",  32'(first), 1);
      chk("contiguous", 32'(last - first + 1), 32'(n_got));
      chk("ack_cnt",    32'(ack_cnt), 1);
      chk("ack_cyc",    32'(ack_cyc), 32'(last + 1));
      for (int i = 0; i < 20 + int'(len) && i < n_got && i < 64; i++)
        chk($sformatf("byte%0d", i), 32'(got_b[i]), 32'(exp_b[i]));
    end
    @(negedge clk);
  endtask

  initial begin
    rst               = 1'b1;
    udp_send_request  = 1'b0;
    udp_data_in_valid = 1'b0;
    udp_data_in       = 8'h00;
    udp_packet_length = 16'h0000;
    dest_ip           = 32'h0;
    mac_send_ready    = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // len 16: base checksum B76A at id 0, one less per id step.
    send_pkt(16'h0010, 0,  0,  -1, 16'(0 * ID_INC), 16'hB76A - 16'(0 * ID_INC), 8'h10);
    send_pkt(16'h0010, 0,  0,  -1, 16'(1 * ID_INC), 16'hB76A - 16'(1 * ID_INC), 8'h20);
    send_pkt(16'h0010, 50, 0,  -1, 16'(2 * ID_INC), 16'hB76A - 16'(2 * ID_INC), 8'h30);
    send_pkt(16'h0010, 0,  10, -1, 16'(3 * ID_INC), 16'hB76A - 16'(3 * ID_INC), 8'h40);
    send_pkt(16'h0010, 0,  0,  5,  16'(4 * ID_INC), 16'hB76A - 16'(4 * ID_INC), 8'h50);
    // Reset clears the identification counter.
    send_pkt(16'h0010, 0,  0,  -1, 16'h0000, 16'hB76A, 8'h60);
    // len 8: total length 0x001C, base checksum B772.
    send_pkt(16'h0008, 0,  0,  -1, 16'(1 * ID_INC), 16'hB772 - 16'(1 * ID_INC), 8'h70);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
